// File: rtl/countdown_timer_if.sv
// Control/status bundle between a tick-driven countdown timer and its user.
// The master drives commands and tick qualification; the slave returns count and status.
interface countdown_timer_if #(
   parameter int MAX_LOAD = 255
);
   localparam int W = (MAX_LOAD < 1) ? 1 : $clog2(MAX_LOAD + 1);

   logic         load;
   logic [W-1:0] load_value;
   logic         start;
   logic         pause;
   logic         auto_reload;
   logic         tick_en;
   logic [W-1:0] count;
   logic         busy;
   logic         done;
   logic         expired;

   modport master (
      output load, load_value, start, pause, auto_reload, tick_en,
      input  count, busy, done, expired
   );

   modport slave (
      input  load, load_value, start, pause, auto_reload, tick_en,
      output count, busy, done, expired
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, optional auto-reload and an expiry pulse.
// Decrements once per qualified tick while running; every output is registered.
module countdown_timer #(
   parameter int MAX_LOAD = 255
) (
   input  logic              clk,
   input  logic              reset,
   countdown_timer_if.slave  bus
);
   localparam int W = (MAX_LOAD < 1) ? 1 : $clog2(MAX_LOAD + 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

   state_t       state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] reload_q, reload_d;
   logic         expired_q, expired_d;
   logic         busy_q, done_q;
   logic [W-1:0] load_sat;

   // Compared one bit wider so the check stays meaningful when MAX_LOAD fills W bits.
   always_comb begin
      if ({1'b0, bus.load_value} > (W+1)'(MAX_LOAD))
         load_sat = W'(MAX_LOAD);
      else
         load_sat = bus.load_value;
   end

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      expired_d = 1'b0;

      if (bus.load) begin
         count_d  = load_sat;
         reload_d = load_sat;
         state_d  = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (count_q != '0) begin
                     state_d = RUN;
                  end else begin
                     state_d   = DONE;
                     expired_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (bus.pause) begin
                  state_d = PAUSED;
               end else if (bus.tick_en) begin
                  if (count_q > W'(1)) begin
                     count_d = count_q - W'(1);
                  end else if (count_q == W'(1)) begin
                     expired_d = 1'b1;
                     if (bus.auto_reload && reload_q != '0) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = DONE;
                     end
                  end
               end
            end
            PAUSED: begin
               if (!bus.pause)
                  state_d = RUN;
            end
            DONE: begin
               if (bus.start) begin
                  count_d = reload_q;
                  if (reload_q != '0)
                     state_d = RUN;
                  else
                     expired_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         expired_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         expired_q <= expired_d;
         busy_q    <= (state_d == RUN) || (state_d == PAUSED);
         done_q    <= (state_d == DONE);
      end
   end

   assign bus.count   = count_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.expired = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed scenarios plus a randomized run against a behavioural timer model.
module tb_countdown_timer;
   localparam int MAXL = 200;
   localparam int W    = 8;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   countdown_timer_if #(.MAX_LOAD(MAXL)) bus ();

   countdown_timer #(.MAX_LOAD(MAXL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load = 0; bus.load_value = '0; bus.start = 0;
      bus.pause = 0; bus.auto_reload = 0; bus.tick_en = 0;
   endtask

   task automatic do_load(input int v);
      bus.load = 1; bus.load_value = W'(v);
      tick();
      bus.load = 0;
   endtask

   task automatic do_start();
      bus.start = 1;
      tick();
      bus.start = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      tick(); tick();
      reset = 0;
      checks++;
      if (bus.count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
      checks++;
      if ({bus.busy, bus.done, bus.expired} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.expired});
      end
   endtask

   task automatic test_countdown();
      do_load(5);
      checks++;
      if (bus.count !== 8'd5 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL t1_load: got count=%0d busy=%b want 5/0", bus.count, bus.busy);
      end
      bus.tick_en = 1;
      do_start();
      checks++;
      if (bus.count !== 8'd5 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL t1_start: got count=%0d busy=%b want 5/1", bus.count, bus.busy);
      end
      for (int e = 4; e >= 1; e--) begin
         tick();
         checks++;
         if (bus.count !== W'(e) || bus.expired !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_dec: got count=%0d exp=%b busy=%b want %0d/0/1", bus.count, bus.expired, bus.busy, e);
         end
      end
      tick();
      checks++;
      if ({bus.count, bus.expired, bus.done, bus.busy} !== {8'd0, 3'b110}) begin
         errors++;
         $display("FAIL t1_expire: got count=%0d exp=%b done=%b busy=%b want 0/1/1/0",
                  bus.count, bus.expired, bus.done, bus.busy);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({bus.count, bus.expired, bus.done, bus.busy} !== {8'd0, 3'b010}) begin
            errors++;
            $display("FAIL t1_hold: got count=%0d exp=%b done=%b busy=%b want 0/0/1/0",
                     bus.count, bus.expired, bus.done, bus.busy);
         end
      end
      bus.tick_en = 0;
      do_start();
      checks++;
      if (bus.count !== 8'd5 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         errors++; $display("FAIL t1_restart: got count=%0d busy=%b done=%b want 5/1/0", bus.count, bus.busy, bus.done);
      end
   endtask

   task automatic test_saturate();
      int n_exp;
      int at;
      do_load(255);
      checks++;
      if (bus.count !== 8'd200) begin errors++; $display("FAIL t2_sat: got %0d want 200", bus.count); end
      do_start();
      bus.tick_en = 1;
      n_exp = 0;
      at = -1;
      for (int i = 1; i <= 205; i++) begin
         tick();
         if (bus.expired) begin n_exp++; at = i; end
      end
      bus.tick_en = 0;
      checks++;
      if (n_exp != 1 || at != 200) begin
         errors++; $display("FAIL t2_expiry: got %0d pulses at tick %0d want 1 at 200", n_exp, at);
      end
      checks++;
      if (bus.done !== 1'b1) begin errors++; $display("FAIL t2_done: got %b want 1", bus.done); end
   endtask

   task automatic test_auto_reload();
      int seq[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 0};
      do_load(3);
      bus.auto_reload = 1;
      do_start();
      for (int k = 0; k < 9; k++) begin
         if (k == 6) bus.auto_reload = 0;
         for (int c = 0; c < 4; c++) begin
            bus.tick_en = (c == 0);
            tick();
            checks++;
            if (bus.count !== W'(seq[k])) begin
               errors++; $display("FAIL t3_count: got %0d want %0d (tick %0d)", bus.count, seq[k], k);
            end
            checks++;
            if (bus.expired !== (c == 0 && (k == 2 || k == 5 || k == 8))) begin
               errors++; $display("FAIL t3_expired: got %b (tick %0d cyc %0d)", bus.expired, k, c);
            end
            checks++;
            if (bus.busy !== (k < 8)) begin
               errors++; $display("FAIL t3_busy: got %b want %b (tick %0d)", bus.busy, k < 8, k);
            end
         end
      end
      bus.tick_en = 0;
      checks++;
      if (bus.done !== 1'b1) begin errors++; $display("FAIL t3_done: got %b want 1", bus.done); end
   endtask

   task automatic test_pause();
      int exp_cnt;
      do_load(10);
      do_start();
      bus.tick_en = 1;
      repeat (4) tick();
      checks++;
      if (bus.count !== 8'd6) begin errors++; $display("FAIL t4_pre: got %0d want 6", bus.count); end
      bus.pause = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (bus.count !== 8'd6 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL t4_paused: got count=%0d busy=%b want 6/1", bus.count, bus.busy);
         end
      end
      bus.pause = 0;
      tick();
      exp_cnt = 6;
      for (int i = 0; i < 2; i++) begin
         tick();
         exp_cnt--;
         checks++;
         if (bus.count !== W'(exp_cnt)) begin
            errors++; $display("FAIL t4_resume: got %0d want %0d", bus.count, exp_cnt);
         end
      end
      bus.pause = 1;
      tick();
      bus.pause = 0;
      tick();
      checks++;
      if (bus.count !== 8'd4) begin errors++; $display("FAIL t4_pause_tick: got %0d want 4", bus.count); end
      tick();
      checks++;
      if (bus.count !== 8'd3) begin errors++; $display("FAIL t4_after: got %0d want 3", bus.count); end
      bus.tick_en = 0;
   endtask

   task automatic test_load_cases();
      do_load(0);
      do_start();
      checks++;
      if ({bus.expired, bus.done, bus.busy} !== 3'b110) begin
         errors++; $display("FAIL t5_zero_start: got exp/done/busy=%b want 110", {bus.expired, bus.done, bus.busy});
      end
      tick();
      checks++;
      if (bus.expired !== 1'b0) begin errors++; $display("FAIL t5_single: got %b want 0", bus.expired); end
      do_start();
      checks++;
      if ({bus.expired, bus.done, bus.count} !== {2'b11, 8'd0}) begin
         errors++; $display("FAIL t5_done_restart: got exp=%b done=%b count=%0d want 1/1/0", bus.expired, bus.done, bus.count);
      end
      bus.load = 1; bus.load_value = 8'd7; bus.start = 1; bus.tick_en = 1;
      tick();
      bus.load = 0; bus.start = 0; bus.tick_en = 0;
      checks++;
      if (bus.count !== 8'd7 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL t5_load_start: got count=%0d busy=%b done=%b want 7/0/0", bus.count, bus.busy, bus.done);
      end
      do_start();
      bus.tick_en = 1;
      repeat (5) tick();
      checks++;
      if (bus.count !== 8'd2) begin errors++; $display("FAIL t5_pre: got %0d want 2", bus.count); end
      bus.load = 1; bus.load_value = 8'd9;
      tick();
      bus.load = 0;
      checks++;
      if ({bus.count, bus.busy, bus.expired} !== {8'd9, 2'b00}) begin
         errors++; $display("FAIL t5_load_run: got count=%0d busy=%b exp=%b want 9/0/0", bus.count, bus.busy, bus.expired);
      end
      repeat (2) tick();
      checks++;
      if (bus.count !== 8'd9 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL t5_idle_ticks: got count=%0d busy=%b want 9/0", bus.count, bus.busy);
      end
      bus.tick_en = 0;
   endtask

   task automatic test_reset_mid_run();
      do_load(8);
      do_start();
      bus.tick_en = 1;
      repeat (4) tick();
      checks++;
      if (bus.count !== 8'd4) begin errors++; $display("FAIL t6_pre: got %0d want 4", bus.count); end
      reset = 1;
      tick();
      reset = 0;
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.expired} !== {8'd0, 3'b000}) begin
         errors++; $display("FAIL t6_reset: got count=%0d busy=%b done=%b exp=%b want 0/0/0/0",
                            bus.count, bus.busy, bus.done, bus.expired);
      end
      tick();
      checks++;
      if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.expired !== 1'b0) begin
         errors++; $display("FAIL t6_after: got count=%0d busy=%b exp=%b want 0/0/0", bus.count, bus.busy, bus.expired);
      end
      bus.tick_en = 0;
   endtask

   // Behavioural model: mode 0 idle, 1 counting, 2 frozen, 3 finished.
   task automatic test_random();
      int m_count = 0, m_reload = 0, m_mode = 0;
      bit m_exp;
      bit r, ld, st, pa, ar, te;
      int lv;
      idle_inputs();
      reset = 1; tick(); reset = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         r  = ($urandom_range(0, 299) == 0);
         ld = ($urandom_range(0, 19) == 0);
         lv = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 255);
         st = ($urandom_range(0, 5) == 0);
         pa = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 30) == 0) ar = ~ar;
         te = $urandom_range(0, 1);
         reset = r; bus.load = ld; bus.load_value = W'(lv); bus.start = st;
         bus.pause = pa; bus.auto_reload = ar; bus.tick_en = te;

         m_exp = 0;
         if (r) begin
            m_count = 0; m_reload = 0; m_mode = 0;
         end else if (ld) begin
            m_count  = (lv > MAXL) ? MAXL : lv;
            m_reload = m_count;
            m_mode   = 0;
         end else if (m_mode == 0) begin
            if (st) begin
               if (m_count == 0) begin m_mode = 3; m_exp = 1; end
               else m_mode = 1;
            end
         end else if (m_mode == 1) begin
            if (pa) m_mode = 2;
            else if (te) begin
               m_count = m_count - 1;
               if (m_count == 0) begin
                  m_exp = 1;
                  if (ar && m_reload != 0) m_count = m_reload;
                  else m_mode = 3;
               end
            end
         end else if (m_mode == 2) begin
            if (!pa) m_mode = 1;
         end else begin
            if (st) begin
               m_count = m_reload;
               if (m_reload == 0) m_exp = 1;
               else m_mode = 1;
            end
         end

         tick();
         checks++;
         if (bus.count !== W'(m_count)) begin
            errors++; $display("FAIL rnd_count: cycle %0d got %0d want %0d", cyc, bus.count, m_count);
         end
         checks++;
         if (bus.expired !== m_exp) begin
            errors++; $display("FAIL rnd_expired: cycle %0d got %b want %b", cyc, bus.expired, m_exp);
         end
         checks++;
         if (bus.busy !== (m_mode == 1 || m_mode == 2)) begin
            errors++; $display("FAIL rnd_busy: cycle %0d got %b want %b", cyc, bus.busy, m_mode == 1 || m_mode == 2);
         end
         checks++;
         if (bus.done !== (m_mode == 3)) begin
            errors++; $display("FAIL rnd_done: cycle %0d got %b want %b", cyc, bus.done, m_mode == 3);
         end
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_countdown();
      test_reset();
      test_saturate();
      test_auto_reload();
      test_pause();
      test_load_cases();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
